// File: rtl/rotate_stepper.sv
// Timed rotation sequencer: loads an 8-bit pattern and steps it through an
// external rotator once every TICK_DIV clocks, for a finite or unbounded count.
module rotate_stepper #(
   parameter int unsigned TICK_DIV = 25_000_000
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       load,
   input  logic [7:0] data_in,
   input  logic       dir_in,
   input  logic [2:0] step_in,
   input  logic [7:0] nsteps_in,
   input  logic       pause,
   input  logic       stop,
   output logic [7:0] shf_a,
   output logic [2:0] shf_amt,
   output logic       shf_lr,
   input  logic [7:0] shf_y,
   output logic [7:0] pattern,
   output logic       busy,
   output logic       done,
   output logic [7:0] step_count
);

   localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] TICK_MAX = CW'(TICK_DIV - 1);

   typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

   state_t        state, state_nx;
   logic [CW-1:0] tick_cnt, tick_cnt_nx;
   logic [7:0]    target, target_nx;
   logic [7:0]    pat_nx, cnt_nx;
   logic [2:0]    amt_nx;
   logic          lr_nx, done_nx;

   assign pattern = shf_a;

   always_comb begin
      state_nx    = state;
      tick_cnt_nx = tick_cnt;
      target_nx   = target;
      pat_nx      = shf_a;
      amt_nx      = shf_amt;
      lr_nx       = shf_lr;
      cnt_nx      = step_count;
      done_nx     = 1'b0;

      if (stop) begin
         state_nx    = IDLE;
         tick_cnt_nx = '0;
      end else if (load) begin
         state_nx    = RUN;
         tick_cnt_nx = '0;
         target_nx   = nsteps_in;
         pat_nx      = data_in;
         amt_nx      = step_in;
         lr_nx       = dir_in;
         cnt_nx      = '0;
      end else if (state != IDLE) begin
         if (pause) begin
            state_nx = PAUSE;
         end else begin
            // Leaving PAUSE counts this cycle, so a pause of N cycles delays the next step by exactly N.
            state_nx = RUN;
            if (tick_cnt == TICK_MAX) begin
               tick_cnt_nx = '0;
               pat_nx      = shf_y;
               cnt_nx      = step_count + 8'd1;
               if ((target != '0) && (cnt_nx == target)) begin
                  done_nx  = 1'b1;
                  state_nx = IDLE;
               end
            end else begin
               tick_cnt_nx = tick_cnt + CW'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         tick_cnt   <= '0;
         target     <= '0;
         shf_a      <= '0;
         shf_amt    <= '0;
         shf_lr     <= 1'b0;
         step_count <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         state      <= state_nx;
         tick_cnt   <= tick_cnt_nx;
         target     <= target_nx;
         shf_a      <= pat_nx;
         shf_amt    <= amt_nx;
         shf_lr     <= lr_nx;
         step_count <= cnt_nx;
         busy       <= (state_nx != IDLE);
         done       <= done_nx;
      end
   end

endmodule

// File: tb/tb_rotate_stepper.sv
// Bench for rotate_stepper with TICK_DIV = 4: an elapsed-time reference model
// checked every cycle, plus directed scenarios with literal expectations.
module tb_rotate_stepper;

   localparam int unsigned TD = 4;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       load, dir_in, pause, stop;
   logic [7:0] data_in, nsteps_in;
   logic [2:0] step_in;
   logic [7:0] shf_a, shf_y, pattern, step_count;
   logic [2:0] shf_amt;
   logic       shf_lr, busy, done;

   int checks = 0;
   int errors = 0;

   rotate_stepper #(.TICK_DIV(TD)) dut (
      .clk(clk), .reset_n(reset_n), .load(load), .data_in(data_in),
      .dir_in(dir_in), .step_in(step_in), .nsteps_in(nsteps_in),
      .pause(pause), .stop(stop), .shf_a(shf_a), .shf_amt(shf_amt),
      .shf_lr(shf_lr), .shf_y(shf_y), .pattern(pattern), .busy(busy),
      .done(done), .step_count(step_count)
   );

   always #5 clk = ~clk;

   // External rotator: double-width shift
   always_comb begin
      logic [15:0] w;
      w = {shf_a, shf_a};
      if (shf_lr) shf_y = 8'(w >> shf_amt);
      else        shf_y = 8'((w << shf_amt) >> 8);
   end

   // Reference rotation: one bit at a time
   function automatic logic [7:0] rot_ref(input logic [7:0] p, input int amt, input logic right);
      logic [7:0] r;
      r = p;
      for (int i = 0; i < amt; i++)
         r = right ? {r[0], r[7:1]} : {r[6:0], r[7]};
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: a run steps whenever its count of unpaused cycles reaches a multiple of TD
   logic [7:0] m_pat = '0, m_cnt = '0, m_target = '0;
   logic [2:0] m_amt = '0;
   logic       m_dir = 1'b0, m_busy = 1'b0, m_done = 1'b0;
   int         m_elapsed = 0;

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_pat = '0; m_cnt = '0; m_target = '0; m_amt = '0;
         m_dir = 1'b0; m_busy = 1'b0; m_done = 1'b0; m_elapsed = 0;
      end else begin
         m_done = 1'b0;
         if (stop) begin
            m_busy = 1'b0;
         end else if (load) begin
            m_pat = data_in; m_dir = dir_in; m_amt = step_in; m_target = nsteps_in;
            m_cnt = '0; m_elapsed = 0; m_busy = 1'b1;
         end else if (m_busy && !pause) begin
            m_elapsed++;
            if (m_elapsed % TD == 0) begin
               m_pat = rot_ref(m_pat, int'(m_amt), m_dir);
               m_cnt = m_cnt + 8'd1;
               if (m_target != 0 && m_cnt == m_target) begin
                  m_done = 1'b1;
                  m_busy = 1'b0;
               end
            end
         end
      end
   end

   always @(negedge clk) begin
      chk("pattern", pattern, m_pat);
      chk("shf_a", shf_a, m_pat);
      chk("shf_amt", shf_amt, m_amt);
      chk("shf_lr", shf_lr, m_dir);
      chk("busy", busy, m_busy);
      chk("done", done, m_done);
      chk("step_count", step_count, m_cnt);
   end

   task automatic do_load(input logic [7:0] d, input logic dir, input logic [2:0] st, input logic [7:0] n);
      data_in = d; dir_in = dir; step_in = st; nsteps_in = n; load = 1'b1;
      @(negedge clk);
      load = 1'b0;
   endtask

   initial begin
      reset_n = 1'b0; load = 1'b0; stop = 1'b0; pause = 1'b0;
      data_in = '0; dir_in = 1'b0; step_in = '0; nsteps_in = '0;
      repeat (2) @(negedge clk);
      chk("rst_pattern", pattern, 8'h00);
      chk("rst_busy", busy, 1'b0);
      chk("rst_count", step_count, 8'd0);
      reset_n = 1'b1;
      @(negedge clk);

      // Finite left run
      do_load(8'h81, 1'b0, 3'd1, 8'd3);
      repeat (4) @(negedge clk);
      chk("fin_step1", pattern, 8'h03);
      chk("fin_busy", busy, 1'b1);
      repeat (4) @(negedge clk);
      chk("fin_step2", pattern, 8'h06);
      repeat (4) @(negedge clk);
      chk("fin_step3", pattern, 8'h0C);
      chk("fin_done", done, 1'b1);
      chk("fin_idle", busy, 1'b0);
      chk("fin_count", step_count, 8'd3);
      @(negedge clk);
      chk("fin_done_drop", done, 1'b0);
      chk("fin_hold", pattern, 8'h0C);

      // Continuous right run through count wrap
      do_load(8'h01, 1'b1, 3'd4, 8'd0);
      repeat (4) @(negedge clk);
      chk("cont_step1", pattern, 8'h10);
      repeat (4) @(negedge clk);
      chk("cont_step2", pattern, 8'h01);
      repeat (253 * 4) @(negedge clk);
      chk("cont_cnt255", step_count, 8'd255);
      chk("cont_pat255", pattern, 8'h10);
      repeat (4) @(negedge clk);
      chk("cont_wrap", step_count, 8'd0);
      chk("cont_pat256", pattern, 8'h01);
      chk("cont_busy", busy, 1'b1);
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
      chk("cont_stop_busy", busy, 1'b0);
      chk("cont_stop_pat", pattern, 8'h01);

      // Pause mid-interval for 10 cycles
      do_load(8'hF0, 1'b0, 3'd1, 8'd0);
      repeat (2) @(negedge clk);
      pause = 1'b1;
      repeat (10) @(negedge clk);
      chk("pause_frozen", pattern, 8'hF0);
      chk("pause_busy", busy, 1'b1);
      pause = 1'b0;
      @(negedge clk);
      chk("pause_not_yet", pattern, 8'hF0);
      @(negedge clk);
      chk("pause_step", pattern, 8'hE1);

      // Stop wins over load
      @(negedge clk);
      stop = 1'b1; load = 1'b1; data_in = 8'h55;
      @(negedge clk);
      stop = 1'b0; load = 1'b0;
      chk("stopld_pat", pattern, 8'hE1);
      chk("stopld_busy", busy, 1'b0);
      chk("stopld_done", done, 1'b0);
      chk("stopld_count", step_count, 8'd1);
      repeat (6) @(negedge clk);
      chk("idle_hold", pattern, 8'hE1);

      // Asynchronous reset mid-run, then a zero-amount finite run
      do_load(8'h3C, 1'b0, 3'd1, 8'd0);
      repeat (6) @(negedge clk);
      #2 reset_n = 1'b0;
      #1;
      chk("arst_pattern", pattern, 8'h00);
      chk("arst_amt", shf_amt, 3'd0);
      chk("arst_lr", shf_lr, 1'b0);
      chk("arst_busy", busy, 1'b0);
      chk("arst_done", done, 1'b0);
      chk("arst_count", step_count, 8'd0);
      @(negedge clk);
      load = 1'b1; data_in = 8'h77; pause = 1'b1;
      repeat (2) @(negedge clk);
      chk("arst_ign_pat", pattern, 8'h00);
      chk("arst_ign_busy", busy, 1'b0);
      load = 1'b0; pause = 1'b0;
      #2 reset_n = 1'b1;
      @(negedge clk);
      do_load(8'hAA, 1'b0, 3'd0, 8'd2);
      repeat (4) @(negedge clk);
      chk("zero_step1", pattern, 8'hAA);
      chk("zero_cnt1", step_count, 8'd1);
      chk("zero_nodone", done, 1'b0);
      repeat (4) @(negedge clk);
      chk("zero_pat", pattern, 8'hAA);
      chk("zero_done", done, 1'b1);
      chk("zero_cnt2", step_count, 8'd2);
      chk("zero_idle", busy, 1'b0);
      @(negedge clk);
      chk("zero_done_drop", done, 1'b0);
      repeat (2) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
